// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg
// Shared MIPS core definitions: word width, opcodes and the fetch FSM state type.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    function automatic logic [5:0] opcodeOf(input logic [WORD_W-1:0] word);
        return word[31:26];
    endfunction

endpackage

`default_nettype wire

// File: rtl/next_pc_calc.sv
// ============================================================================
// next_pc_calc
// Combinational next-PC selection for the fetch stage: jump, branch or pc+4.
// Revision: 1.0
// ============================================================================
`default_nettype none

module next_pc_calc
    import mips_pkg::*;
(
    input  logic [WORD_W-1:0] pc,
    input  logic [WORD_W-1:0] instr,
    input  logic              Branch,
    input  logic              Bne,
    input  logic              Jump,
    input  logic              Jal,
    input  logic              eq,
    output logic [WORD_W-1:0] next_pc,
    output logic              taken
);

    logic [WORD_W-1:0] w_pc4;
    logic [WORD_W-1:0] w_jumpTarget;
    logic [WORD_W-1:0] w_branchTarget;
    logic              w_isJump;
    logic              w_isBranch;
    logic              w_unusedOpcode;

    assign w_pc4          = pc + 32'd4;
    assign w_jumpTarget   = {w_pc4[31:28], instr[25:0], 2'b00};
    assign w_branchTarget = w_pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};

    assign w_isJump   = Jump | Jal;
    assign w_isBranch = (Branch & eq) | (Bne & ~eq);

    // Jumps outrank branches when decode asserts both.
    always_comb begin
        next_pc = w_pc4;
        if (w_isJump) begin
            next_pc = w_jumpTarget;
        end else if (w_isBranch) begin
            next_pc = w_branchTarget;
        end
    end

    assign taken = w_isJump | w_isBranch;

    // Opcode field is decoded upstream; not needed for target arithmetic.
    assign w_unusedOpcode = ^instr[31:26];

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// pc_fetch_unit
// PC register and instruction-fetch FSM over a valid/ready imem port.
// Optional macro: BRANCH_DELAY_SLOT_EN (one-instruction branch delay slot).
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC      = 32'h0000_0000,
    parameter int                FETCH_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] instr,
    output logic [5:0]        opcode,
    output logic              instr_valid,
    input  logic              instr_ack,
    input  logic              Branch,
    input  logic              Bne,
    input  logic              Jump,
    input  logic              Jal,
    input  logic              eq,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] link_addr,
    output logic              fetch_err
);

    localparam logic [7:0] c_TIMEOUT = 8'(FETCH_TIMEOUT);

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic [WORD_W-1:0] c_LINK_OFFSET = 32'd8;
`else
    localparam logic [WORD_W-1:0] c_LINK_OFFSET = 32'd4;
`endif

    fetch_state_t      r_state;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_instr;
    logic              r_instrValid;
    logic              r_imemReq;
    logic              r_fetchErr;
    logic [7:0]        r_timeoutCnt;

    logic [WORD_W-1:0] w_nextPc;
    logic              w_taken;
    logic [7:0]        w_cntNext;

    next_pc_calc u_nextPc (
        .pc      (r_pc),
        .instr   (r_instr),
        .Branch  (Branch),
        .Bne     (Bne),
        .Jump    (Jump),
        .Jal     (Jal),
        .eq      (eq),
        .next_pc (w_nextPc),
        .taken   (w_taken)
    );

    assign w_cntNext = r_timeoutCnt + 8'd1;

`ifdef BRANCH_DELAY_SLOT_EN
    logic              r_pendingValid;
    logic [WORD_W-1:0] r_pendingTarget;
    logic [WORD_W-1:0] w_pc4;

    assign w_pc4 = r_pc + 32'd4;
`else
    logic w_unusedTaken;

    assign w_unusedTaken = w_taken;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_instr      <= '0;
            r_instrValid <= 1'b0;
            r_imemReq    <= 1'b0;
            r_fetchErr   <= 1'b0;
            r_timeoutCnt <= '0;
`ifdef BRANCH_DELAY_SLOT_EN
            r_pendingValid  <= 1'b0;
            r_pendingTarget <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_state   <= FETCH;
                    r_imemReq <= 1'b1;
                end
                FETCH: begin
                    if (imem_ready) begin
                        r_instr      <= imem_rdata;
                        r_instrValid <= 1'b1;
                        r_imemReq    <= 1'b0;
                        r_state      <= HOLD;
                    end else if (w_cntNext == c_TIMEOUT) begin
                        r_fetchErr <= 1'b1;
                        r_imemReq  <= 1'b0;
                        r_state    <= HALT;
                    end else begin
                        r_timeoutCnt <= w_cntNext;
                    end
                end
                HOLD: begin
                    if (instr_ack) begin
`ifdef BRANCH_DELAY_SLOT_EN
                        // A redirect already pending wins over whatever the slot decodes.
                        if (r_pendingValid) begin
                            r_pc           <= r_pendingTarget;
                            r_pendingValid <= 1'b0;
                        end else begin
                            r_pc            <= w_pc4;
                            r_pendingValid  <= w_taken;
                            r_pendingTarget <= w_nextPc;
                        end
`else
                        r_pc <= w_nextPc;
`endif
                        r_instrValid <= 1'b0;
                        r_timeoutCnt <= '0;
                        r_imemReq    <= 1'b1;
                        r_state      <= FETCH;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign imem_req    = r_imemReq;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign opcode      = opcodeOf(r_instr);
    assign instr_valid = r_instrValid;
    assign fetch_err   = r_fetchErr;
    assign link_addr   = r_pc + c_LINK_OFFSET;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// tb_pc_fetch_unit
// Directed self-checking bench for pc_fetch_unit (both BRANCH_DELAY_SLOT_EN builds).
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pc_fetch_unit;

    localparam int          TO   = 8;
    localparam logic [31:0] NOP  = 32'h0000_0020;
    localparam logic [31:0] BEQ  = 32'h1022_FFFC;
    localparam logic [31:0] BNE  = 32'h1422_0003;
    localparam logic [31:0] JAL  = 32'h0C00_0040;
    localparam logic [31:0] J40  = 32'h0800_0010;
    localparam logic [31:0] J80  = 32'h0800_0020;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        instr_ack;
    logic        Branch, Bne, Jump, Jal, eq;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .RESET_PC      (32'h0000_0000),
        .FETCH_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .instr_ack   (instr_ack),
        .Branch      (Branch),
        .Bne         (Bne),
        .Jump        (Jump),
        .Jal         (Jal),
        .eq          (eq),
        .pc          (pc),
        .link_addr   (link_addr),
        .fetch_err   (fetch_err)
    );

    // Stimulus helpers: all input changes happen just after a falling edge.
    task automatic clearInputs();
        imem_ready = 1'b0; imem_rdata = '0; instr_ack = 1'b0;
        Branch = 1'b0; Bne = 1'b0; Jump = 1'b0; Jal = 1'b0; eq = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        clearInputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic serve(input logic [31:0] word);
        imem_ready = 1'b1; imem_rdata = word;
        @(negedge clk);
        imem_ready = 1'b0; imem_rdata = '0;
    endtask

    task automatic retire(input logic br, input logic bn, input logic j, input logic jl, input logic e);
        instr_ack = 1'b1; Branch = br; Bne = bn; Jump = j; Jal = jl; eq = e;
        @(negedge clk);
        instr_ack = 1'b0; Branch = 1'b0; Bne = 1'b0; Jump = 1'b0; Jal = 1'b0; eq = 1'b0;
    endtask

    task automatic step(input logic [31:0] word, input logic br, input logic bn,
                        input logic j, input logic jl, input logic e);
        serve(word);
        retire(br, bn, j, jl, e);
    endtask

    task automatic gotoPc10();
        doReset();
        repeat (4) step(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clearInputs();
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req got=%0h exp=0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%0h exp=0", instr_valid); end
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instr, 32'h0); end
        checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL reset_fetch_err got=%0h exp=0", fetch_err); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL reset_first_req got=%0h exp=1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_first_addr got=%h exp=%h", imem_addr, 32'h0); end
    endtask

    task automatic test_sequential();
        doReset();
        // Ack while still fetching must not move the PC.
        instr_ack = 1'b1;
        @(negedge clk);
        instr_ack = 1'b0;
        checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin failures++; $display("FAIL seq_ack_in_fetch addr=%h req=%0h exp addr=0 req=1", imem_addr, imem_req); end
        serve(NOP);
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL seq_valid got=%0h exp=1", instr_valid); end
        checks++; if (instr !== NOP) begin failures++; $display("FAIL seq_instr got=%h exp=%h", instr, NOP); end
        checks++; if (opcode !== 6'h00) begin failures++; $display("FAIL seq_opcode got=%h exp=00", opcode); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL seq_req_hold got=%0h exp=0", imem_req); end
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL seq_pc_hold got=%h exp=%h", pc, 32'h0); end
        retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL seq_addr1 got=%h exp=%h", imem_addr, 32'h4); end
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin failures++; $display("FAIL seq_refetch valid=%0h req=%0h exp valid=0 req=1", instr_valid, imem_req); end
        step(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL seq_addr2 got=%h exp=%h", imem_addr, 32'h8); end
    endtask

    task automatic test_beq();
        gotoPc10();
        checks++; if (imem_addr !== 32'h10) begin failures++; $display("FAIL beq_start got=%h exp=%h", imem_addr, 32'h10); end
        serve(BEQ);
        checks++; if (opcode !== 6'h04) begin failures++; $display("FAIL beq_opcode got=%h exp=04", opcode); end
        retire(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef BRANCH_DELAY_SLOT_EN
        checks++; if (imem_addr !== 32'h14) begin failures++; $display("FAIL beq_slot got=%h exp=%h", imem_addr, 32'h14); end
        step(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        checks++; if (imem_addr !== 32'h04) begin failures++; $display("FAIL beq_taken got=%h exp=%h", imem_addr, 32'h04); end
        gotoPc10();
        step(BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (imem_addr !== 32'h14) begin failures++; $display("FAIL beq_not_taken got=%h exp=%h", imem_addr, 32'h14); end
        step(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (imem_addr !== 32'h18) begin failures++; $display("FAIL beq_fallthru got=%h exp=%h", imem_addr, 32'h18); end
    endtask

    task automatic test_bne_jal();
        logic [31:0] expLink;
`ifdef BRANCH_DELAY_SLOT_EN
        expLink = 32'h18;
`else
        expLink = 32'h14;
`endif
        gotoPc10();
        step(BNE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef BRANCH_DELAY_SLOT_EN
        checks++; if (imem_addr !== 32'h14) begin failures++; $display("FAIL bne_slot got=%h exp=%h", imem_addr, 32'h14); end
        step(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        checks++; if (imem_addr !== 32'h20) begin failures++; $display("FAIL bne_taken got=%h exp=%h", imem_addr, 32'h20); end
        gotoPc10();
        serve(JAL);
        checks++; if (opcode !== 6'h03) begin failures++; $display("FAIL jal_opcode got=%h exp=03", opcode); end
        checks++; if (link_addr !== expLink) begin failures++; $display("FAIL jal_link got=%h exp=%h", link_addr, expLink); end
        retire(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef BRANCH_DELAY_SLOT_EN
        checks++; if (imem_addr !== 32'h14) begin failures++; $display("FAIL jal_slot got=%h exp=%h", imem_addr, 32'h14); end
        step(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL jal_target got=%h exp=%h", imem_addr, 32'h100); end
        // Jump and taken branch together: jump target 0x100, branch would give 0x114.
        gotoPc10();
        step(JAL, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef BRANCH_DELAY_SLOT_EN
        step(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL jump_priority got=%h exp=%h", imem_addr, 32'h100); end
    endtask

    task automatic test_timeout();
        doReset();
        repeat (TO - 1) @(negedge clk);
        checks++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin failures++; $display("FAIL timeout_early err=%0h req=%0h exp err=0 req=1", fetch_err, imem_req); end
        @(negedge clk);
        checks++; if (fetch_err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%0h exp=1", fetch_err); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL timeout_req got=%0h exp=0", imem_req); end
        imem_ready = 1'b1; imem_rdata = NOP; instr_ack = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
            failures++; $display("FAIL halt_stuck err=%0h req=%0h valid=%0h addr=%h exp 1 0 0 0", fetch_err, imem_req, instr_valid, imem_addr);
        end
        clearInputs();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL halt_reset_err got=%0h exp=0", fetch_err); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL halt_restart_req got=%0h exp=1", imem_req); end
    endtask

    task automatic test_reset_ignore();
        doReset();
        step(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL rst_ign_pre got=%h exp=%h", imem_addr, 32'h8); end
        reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL rst_ign_idle valid=%0h req=%0h exp 0 0", instr_valid, imem_req); end
        @(negedge clk);
        imem_ready = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_ign_valid got=%0h exp=0", instr_valid); end
        checks++; if (instr !== 32'h0) begin failures++; $display("FAIL rst_ign_instr got=%h exp=%h", instr, 32'h0); end
        checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin failures++; $display("FAIL rst_ign_addr addr=%h req=%0h exp addr=0 req=1", imem_addr, imem_req); end
    endtask

    task automatic test_jump_slot();
        logic [31:0] expLink;
`ifdef BRANCH_DELAY_SLOT_EN
        expLink = 32'h8;
`else
        expLink = 32'h4;
`endif
        doReset();
        serve(J40);
        checks++; if (link_addr !== expLink) begin failures++; $display("FAIL j_link got=%h exp=%h", link_addr, expLink); end
        retire(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef BRANCH_DELAY_SLOT_EN
        checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL j_slot got=%h exp=%h", imem_addr, 32'h4); end
        // A jump in the slot is ignored; the pending target still wins.
        step(J80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
        checks++; if (imem_addr !== 32'h40) begin failures++; $display("FAIL j_target got=%h exp=%h", imem_addr, 32'h40); end
        step(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (imem_addr !== 32'h44) begin failures++; $display("FAIL j_after got=%h exp=%h", imem_addr, 32'h44); end
    endtask

    initial begin
        reset = 1'b1;
        clearInputs();
        test_reset();
        test_sequential();
        test_beq();
        test_bne_jal();
        test_timeout();
        test_reset_ignore();
        test_jump_slot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
